// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and sizing helpers for serial_adder
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  function automatic int calc_ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // Counter must hold 0..NDIG-1 and never collapse to zero bits.
  function automatic int calc_cnt_w(input int ndig);
    if (ndig <= 1) begin
      return 1;
    end
    return $clog2(ndig);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// rtl/digit_adder.sv - combinational DIGIT-bit ripple adder built from half-adder pairs
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  logic [DIGIT:0] w_c;

  assign w_c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    logic w_h1_s;
    logic w_h1_c;
    logic w_h2_c;

    assign w_h1_s   = x[i] ^ y[i];
    assign w_h1_c   = x[i] & y[i];
    assign s[i]     = w_h1_s ^ w_c[i];
    assign w_h2_c   = w_h1_s & w_c[i];
    assign w_c[i+1] = w_h1_c | w_h2_c;
  end

  assign co = w_c[DIGIT];

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - digit-serial WIDTH-bit adder with start/busy/done handshake
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NDIG = calc_ndig(WIDTH, DIGIT);
  localparam int CW   = calc_cnt_w(NDIG);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_done;
  logic             r_busy;

  logic [DIGIT-1:0] w_dig_s;
  logic             w_dig_co;
  logic [WIDTH-1:0] w_next_shift;
  logic [WIDTH-1:0] w_a_shr;
  logic [WIDTH-1:0] w_b_shr;
  logic             w_last;

  digit_adder #(
    .DIGIT(DIGIT)
  ) u_digit_adder (
    .x  (r_a[DIGIT-1:0]),
    .y  (r_b[DIGIT-1:0]),
    .ci (r_carry),
    .s  (w_dig_s),
    .co (w_dig_co)
  );

  // New digits enter at the MSB end so the LSB digit lands at bit 0 after NDIG shifts.
  if (DIGIT == WIDTH) begin : g_single
    assign w_next_shift = w_dig_s;
    assign w_a_shr      = '0;
    assign w_b_shr      = '0;
  end else begin : g_multi
    assign w_next_shift = {w_dig_s, r_shift[WIDTH-1:DIGIT]};
    assign w_a_shr      = {{DIGIT{1'b0}}, r_a[WIDTH-1:DIGIT]};
    assign w_b_shr      = {{DIGIT{1'b0}}, r_b[WIDTH-1:DIGIT]};
  end

  assign w_last = (r_cnt == CW'(NDIG - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_shift <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_RUN: begin
          r_a     <= w_a_shr;
          r_b     <= w_b_shr;
          r_carry <= w_dig_co;
          r_shift <= w_next_shift;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_sum   <= w_next_shift;
            r_cout  <= w_dig_co;
            r_ovf   <= (r_a_msb == r_b_msb) && (w_next_shift[WIDTH-1] != r_a_msb);
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_FIN;
          end
        end
        // IDLE and FIN accept identically, which gives back-to-back operation.
        default: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
            r_carry <= cin;
            r_cnt   <= '0;
            r_shift <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed and exhaustive self-checking bench for serial_adder
module tb_serial_adder;

  logic       clk;
  logic       rst_n;

  logic [7:0] a8, b8;
  logic       cin8, start81, start84;
  logic       busy81, done81, cout81, ovf81;
  logic [7:0] sum81;
  logic       busy84, done84, cout84, ovf84;
  logic [7:0] sum84;

  logic [3:0] a4, b4;
  logic       cin4, start4;
  logic       busy41, done41, cout41, ovf41;
  logic       busy42, done42, cout42, ovf42;
  logic       busy44, done44, cout44, ovf44;
  logic [3:0] sum41, sum42, sum44;

  int n_vec;
  int n_mis;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u8d1 (
    .clk(clk), .rst_n(rst_n), .start(start81), .a(a8), .b(b8), .cin(cin8),
    .busy(busy81), .done(done81), .sum(sum81), .cout(cout81), .overflow(ovf81));

  serial_adder #(.WIDTH(8), .DIGIT(4)) u8d4 (
    .clk(clk), .rst_n(rst_n), .start(start84), .a(a8), .b(b8), .cin(cin8),
    .busy(busy84), .done(done84), .sum(sum84), .cout(cout84), .overflow(ovf84));

  serial_adder #(.WIDTH(4), .DIGIT(1)) u4d1 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy41), .done(done41), .sum(sum41), .cout(cout41), .overflow(ovf41));

  serial_adder #(.WIDTH(4), .DIGIT(2)) u4d2 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy42), .done(done42), .sum(sum42), .cout(cout42), .overflow(ovf42));

  serial_adder #(.WIDTH(4), .DIGIT(4)) u4d4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy44), .done(done44), .sum(sum44), .cout(cout44), .overflow(ovf44));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat1, lat2, lat4;
    int sref;
    logic [4:0] uref;
    logic       oref;

    n_vec   = 0;
    n_mis   = 0;
    rst_n   = 1'b0;
    a8      = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    start81 = 1'b0; start84 = 1'b0;
    a4      = 4'h0; b4 = 4'h0; cin4 = 1'b0; start4 = 1'b0;

    #12;
    check("rst_busy", {31'd0, busy81}, 32'd0);
    check("rst_done", {31'd0, done81}, 32'd0);
    check("rst_sum",  {24'd0, sum81},  32'd0);
    check("rst_cout", {31'd0, cout81}, 32'd0);
    check("rst_ovf",  {31'd0, ovf81},  32'd0);
    check("rst_busy84", {31'd0, busy84}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 0x0F + 0x01, one bit per clock
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start81 = 1'b1;
    tick();
    start81 = 1'b0;
    check("t1_busy_e0", {31'd0, busy81}, 32'd1);
    for (int i = 1; i < 8; i++) begin
      tick();
      check("t1_busy_run", {30'd0, busy81, done81}, 32'd2);
    end
    tick();
    check("t1_done",  {30'd0, busy81, done81}, 32'd1);
    check("t1_sum",   {24'd0, sum81}, 32'h10);
    check("t1_cout",  {31'd0, cout81}, 32'd0);
    check("t1_ovf",   {31'd0, ovf81}, 32'd0);
    tick();
    check("t1_done_drop", {30'd0, busy81, done81}, 32'd0);
    check("t1_sum_hold",  {24'd0, sum81}, 32'h10);

    // 0xFF + 0x01 then back-to-back 0x7F + 0x01
    a8 = 8'hFF; b8 = 8'h01; start81 = 1'b1;
    tick();
    start81 = 1'b0;
    for (int i = 1; i < 8; i++) tick();
    tick();
    check("t2_done", {31'd0, done81}, 32'd1);
    check("t2_sum",  {24'd0, sum81}, 32'h00);
    check("t2_cout", {31'd0, cout81}, 32'd1);
    check("t2_ovf",  {31'd0, ovf81}, 32'd0);
    a8 = 8'h7F; b8 = 8'h01; start81 = 1'b1;
    tick();
    start81 = 1'b0;
    check("t2_b2b_busy", {30'd0, busy81, done81}, 32'd2);
    check("t2_b2b_hold", {23'd0, cout81, sum81}, 32'h100);
    for (int i = 1; i < 8; i++) tick();
    tick();
    check("t2b_done", {31'd0, done81}, 32'd1);
    check("t2b_sum",  {24'd0, sum81}, 32'h80);
    check("t2b_cout", {31'd0, cout81}, 32'd0);
    check("t2b_ovf",  {31'd0, ovf81}, 32'd1);
    tick();

    // 0xAB + 0xCD + 1, four bits per clock
    a8 = 8'hAB; b8 = 8'hCD; cin8 = 1'b1; start84 = 1'b1;
    tick();
    start84 = 1'b0;
    check("t3_busy", {30'd0, busy84, done84}, 32'd2);
    tick();
    check("t3_run",  {30'd0, busy84, done84}, 32'd2);
    tick();
    check("t3_done", {30'd0, busy84, done84}, 32'd1);
    check("t3_sum",  {24'd0, sum84}, 32'h79);
    check("t3_cout", {31'd0, cout84}, 32'd1);
    check("t3_ovf",  {31'd0, ovf84}, 32'd1);
    tick();
    cin8 = 1'b0;

    // start while busy is ignored; operands changing mid-run are ignored
    a8 = 8'h01; b8 = 8'h01; start81 = 1'b1;
    tick();
    start81 = 1'b0;
    for (int i = 1; i < 4; i++) tick();
    a8 = 8'h55; start81 = 1'b1;
    tick();
    start81 = 1'b0;
    check("t4_still_busy", {30'd0, busy81, done81}, 32'd2);
    for (int i = 5; i < 8; i++) tick();
    tick();
    check("t4_done", {31'd0, done81}, 32'd1);
    check("t4_sum",  {24'd0, sum81}, 32'h02);
    check("t4_cout", {31'd0, cout81}, 32'd0);

    // asynchronous reset mid-run discards the operation
    a8 = 8'h10; b8 = 8'h10; start81 = 1'b1;
    tick();
    start81 = 1'b0;
    tick(); tick(); tick();
    check("t5_busy_pre", {31'd0, busy81}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", {31'd0, busy81}, 32'd0);
    check("t5_rst_done", {31'd0, done81}, 32'd0);
    check("t5_rst_sum",  {24'd0, sum81}, 32'd0);
    check("t5_rst_cout", {31'd0, cout81}, 32'd0);
    check("t5_rst_ovf",  {31'd0, ovf81}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t5_no_done", {30'd0, busy81, done81}, 32'd0);
    end

    a8 = 8'h10; b8 = 8'h10; start81 = 1'b1;
    tick();
    start81 = 1'b0;
    for (int i = 1; i < 8; i++) tick();
    tick();
    check("t6_done", {31'd0, done81}, 32'd1);
    check("t6_sum",  {24'd0, sum81}, 32'h20);
    tick();

    // exhaustive WIDTH=4 across DIGIT=1,2,4
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          a4 = 4'(ai); b4 = 4'(bi); cin4 = 1'(ci); start4 = 1'b1;
          tick();
          start4 = 1'b0;
          lat1 = 0; lat2 = 0; lat4 = 0;
          for (int c = 1; c <= 5; c++) begin
            tick();
            if (done41 && lat1 == 0) lat1 = c;
            if (done42 && lat2 == 0) lat2 = c;
            if (done44 && lat4 == 0) lat4 = c;
          end
          uref = 5'(ai + bi + ci);
          sref = ((ai >= 8) ? ai - 16 : ai) + ((bi >= 8) ? bi - 16 : bi) + ci;
          oref = (sref > 7) || (sref < -8);
          check("x_d1_sum", {27'd0, cout41, sum41}, {27'd0, uref});
          check("x_d2_sum", {27'd0, cout42, sum42}, {27'd0, uref});
          check("x_d4_sum", {27'd0, cout44, sum44}, {27'd0, uref});
          check("x_d1_ovf", {31'd0, ovf41}, {31'd0, oref});
          check("x_d2_ovf", {31'd0, ovf42}, {31'd0, oref});
          check("x_d4_ovf", {31'd0, ovf44}, {31'd0, oref});
          check("x_d1_lat", 32'(lat1), 32'd4);
          check("x_d2_lat", 32'(lat2), 32'd2);
          check("x_d4_lat", 32'(lat4), 32'd1);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised, multi-cycle successor to the combinational half adder.
- Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, LSB digit first, with a carry flop between digits.
- Start/busy/done handshake.
- Used where area matters more than latency: small datapaths, bit-serial arithmetic units, teaching/benchmark designs in the combinational-to-sequential progression.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be >= 2.
- DIGIT, 1, bits added per clock; must divide WIDTH exactly; DIGIT == WIDTH gives single-cycle operation.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock, reset asynchronous, active-low.
- start  input  1  request; sampled only when busy == 0.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in; captured on accepted start.
- busy  output  1  high while an addition is in progress.
- done  output  1  single-cycle pulse: result valid.
- sum  output  WIDTH  result; holds last completed value.
- cout  output  1  carry out of MSB; holds with sum.
- overflow  output  1  two's-complement signed overflow; holds with sum.

Behaviour:
- NDIG = WIDTH/DIGIT.
- Reset (rst_n low, any time, async): state=IDLE; busy, done, sum, cout, overflow, digit counter, carry flop, operand regs all 0. Any in-flight operation is discarded, with no done pulse.
- States: IDLE, RUN, FIN.
- IDLE: start=1 at edge E0 -> latch a, b; carry flop <= cin; counter <= 0; go RUN; busy=1 from E0.
- RUN: each edge adds the low DIGIT bits of A and B plus the carry flop.
  - DIGIT-bit result shifts into the result shift register from the MSB end.
  - A and B shift right by DIGIT; carry flop <= digit carry; counter increments.
- On edge EN = E0+NDIG (counter == NDIG-1 before the edge), all of the following load in the same edge:
  - sum <= completed shift register.
  - cout <= final carry.
  - overflow <= (A[MSB]==B[MSB]) && (sum[MSB]!=A[MSB]), using captured operands.
  - done <= 1, busy <= 0, state <= FIN.
- Latency: done is high exactly NDIG cycles after the start-accept edge.
- FIN: lasts one cycle. done=1, busy=0. start=1 here is accepted exactly as in IDLE (back-to-back, no bubble) and goes to RUN; otherwise go to IDLE. done drops at the next edge in either case.
- start while busy=1 is ignored; operands are not re-latched and the running result is unaffected.
- a/b/cin changing while busy does not affect the result.
- sum/cout/overflow change only at completion edges or reset. They stay stable through a following RUN until the next completion.
- Arithmetic is modulo 2^WIDTH with carry exported on cout. {cout,sum} == a + b + cin exactly.
- DIGIT == WIDTH: NDIG = 1, done one cycle after accept.

Decomposition:
- Package serial_adder_pkg holds:
  - State encoding constants (IDLE=2'd0, RUN=2'd1, FIN=2'd2).
  - A helper function computing NDIG and counter width (clog2 of NDIG, minimum 1).
- One sub-module: digit_adder (parameter DIGIT; inputs x, y [DIGIT], ci; outputs s [DIGIT], co). Purely combinational ripple of full adders, each built from two half-adder stages plus OR. All sequencing stays in serial_adder.

Test Plan:
- WIDTH=8, DIGIT=1: a=0x0F, b=0x01, cin=0, start pulse -> busy 8 cycles; done pulse on 8th edge; sum=0x10, cout=0, overflow=0.
- WIDTH=8, DIGIT=1: 0xFF+0x01, cin=0 -> sum=0x00, cout=1, overflow=0. Then 0x7F+0x01 started in the done cycle -> accepted with no gap; sum=0x80, overflow=1, cout=0.
- WIDTH=8, DIGIT=4: a=0xAB, b=0xCD, cin=1 -> done 2 cycles after accept; sum=0x79, cout=1, overflow=1.
- Busy-start and reset:
  - Pulse start with a=0x01, b=0x01; re-pulse start with a=0x55 mid-run -> ignored; sum=0x02.
  - Then start 0x10+0x10 and drop rst_n at cycle 3 -> all outputs 0 immediately, no done pulse.
  - Re-run 0x10+0x10 -> sum=0x20.
- Exhaustive WIDTH=4 with DIGIT=1, 2 and 4: all a, b, cin -> {cout,sum} == a+b+cin; overflow matches the signed reference; done latency == NDIG every time.
